// File: rtl/regfile_write_arbiter.sv
// Two-port register-file writeback arbiter: one holding slot per port, age-ordered
// same-register writes, round-robin otherwise, registered write port and hazard flags.
module regfile_write_arbiter #(
    parameter int unsigned DROP_R0 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [3:0]  req0_reg,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_reg,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    input  logic [3:0]  SrcReg1,
    input  logic [3:0]  SrcReg2,
    output logic        SrcPend1,
    output logic        SrcPend2
);

    localparam bit DropR0 = (DROP_R0 != 0);

    logic [1:0]  slot_vld_q, slot_vld_d;
    logic [3:0]  slot_reg_q  [2];
    logic [3:0]  slot_reg_d  [2];
    logic [15:0] slot_data_q [2];
    logic [15:0] slot_data_d [2];
    logic [1:0]  young_q, young_d;
    logic        rr_q, rr_d;
    logic        wr_q;
    logic [3:0]  dst_reg_q;
    logic [15:0] dst_data_q;

    logic [1:0]  req_valid, ready, gnt, load, stay;
    logic [3:0]  req_reg  [2];
    logic [15:0] req_data [2];

    always_comb begin
        req_valid   = {req1_valid, req0_valid};
        req_reg[0]  = req0_reg;
        req_reg[1]  = req1_reg;
        req_data[0] = req0_data;
        req_data[1] = req1_data;
    end

    // Same-register conflicts go to the older slot to keep per-register order.
    always_comb begin
        gnt = 2'b00;
        case (slot_vld_q)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (slot_reg_q[0] == slot_reg_q[1]) begin
                    gnt = young_q[0] ? 2'b10 : 2'b01;
                end else begin
                    gnt = rr_q ? 2'b10 : 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ready = {2{~rst}} & (~slot_vld_q | gnt);
        stay  = slot_vld_q & ~gnt;
        for (int n = 0; n < 2; n++) begin
            load[n] = req_valid[n] & ready[n] & ~(DropR0 && (req_reg[n] == 4'd0));
        end
    end

    always_comb begin
        slot_vld_d = stay | load;
        for (int n = 0; n < 2; n++) begin
            slot_reg_d[n]  = load[n] ? req_reg[n]  : slot_reg_q[n];
            slot_data_d[n] = load[n] ? req_data[n] : slot_data_q[n];
        end
        // A fresh load is younger if the other slot is still occupied afterwards;
        // on a simultaneous load slot 0 counts as older.
        young_d[0] = load[0] ? stay[1] : (stay[0] & young_q[0] & ~gnt[1]);
        young_d[1] = load[1] ? (stay[0] | load[0]) : (stay[1] & young_q[1] & ~gnt[0]);
        rr_d       = (slot_vld_q == 2'b11) ? gnt[0] : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q     <= 2'b00;
            slot_reg_q[0]  <= 4'd0;
            slot_reg_q[1]  <= 4'd0;
            slot_data_q[0] <= 16'd0;
            slot_data_q[1] <= 16'd0;
            young_q        <= 2'b00;
            rr_q           <= 1'b0;
            wr_q           <= 1'b0;
            dst_reg_q      <= 4'd0;
            dst_data_q     <= 16'd0;
        end else begin
            slot_vld_q     <= slot_vld_d;
            slot_reg_q[0]  <= slot_reg_d[0];
            slot_reg_q[1]  <= slot_reg_d[1];
            slot_data_q[0] <= slot_data_d[0];
            slot_data_q[1] <= slot_data_d[1];
            young_q        <= young_d;
            rr_q           <= rr_d;
            wr_q           <= |gnt;
            if (gnt[0]) begin
                dst_reg_q  <= slot_reg_q[0];
                dst_data_q <= slot_data_q[0];
            end else if (gnt[1]) begin
                dst_reg_q  <= slot_reg_q[1];
                dst_data_q <= slot_data_q[1];
            end
        end
    end

    function automatic logic pending(input logic [3:0] src);
        logic hit;
        hit = (slot_vld_q[0] && slot_reg_q[0] == src) ||
              (slot_vld_q[1] && slot_reg_q[1] == src) ||
              (wr_q && dst_reg_q == src);
        return hit && !(DropR0 && src == 4'd0);
    endfunction

    always_comb begin
        req0_ready = ready[0];
        req1_ready = ready[1];
        WriteReg   = wr_q;
        DstReg     = dst_reg_q;
        DstData    = dst_data_q;
        SrcPend1   = ~rst & pending(SrcReg1);
        SrcPend2   = ~rst & pending(SrcReg2);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus contention
// and mid-flight reset sequences.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_reg, req1_reg, SrcReg1, SrcReg2, DstReg;
    logic [15:0] req0_data, req1_data, DstData;
    logic        WriteReg, SrcPend1, SrcPend2;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.DROP_R0(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_reg  (req0_reg),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg  (req1_reg),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .WriteReg  (WriteReg),
        .DstReg    (DstReg),
        .DstData   (DstData),
        .SrcReg1   (SrcReg1),
        .SrcReg2   (SrcReg2),
        .SrcPend1  (SrcPend1),
        .SrcPend2  (SrcPend2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [3:0]  r0;
        logic [15:0] d0;
        logic        v1;
        logic [3:0]  r1;
        logic [15:0] d1;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        rdy0;
        logic        rdy1;
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] dat;
        logic        p1;
        logic        p2;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] r0, input logic [15:0] d0,
                         input logic v1, input logic [3:0] r1, input logic [15:0] d1,
                         input logic [3:0] s1, input logic [3:0] s2);
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        SrcReg1 = s1; SrcReg2 = s2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".wr"},  {15'd0, WriteReg}, 16'd0);
        check({tag, ".dst"}, {12'd0, DstReg},   16'd0);
        check({tag, ".dat"}, DstData,           16'd0);
        check({tag, ".p1"},  {15'd0, SrcPend1}, 16'd0);
        check({tag, ".p2"},  {15'd0, SrcPend2}, 16'd0);
    endtask

    initial begin
        int          n0, n1, k;
        logic        h0, h1;
        logic [3:0]  exp_reg;
        logic [15:0] exp_dat;

        // Inputs: v0 r0 d0 v1 r1 d1 s1 s2 | expected: rdy0 rdy1 wr dst dat p1 p2
        vecs[0] = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd0,
                    1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3,
                    1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd4,
                    1'b1, 1'b1, 1'b1, 4'd3, 16'h1234, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h5555, 4'd0, 4'd3,
                    1'b1, 1'b1, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 16'hBBBB, 4'd7, 4'd0,
                    1'b1, 1'b1, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7,
                    1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7,
                    1'b1, 1'b1, 1'b1, 4'd7, 16'hAAAA, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd2,
                    1'b1, 1'b1, 1'b1, 4'd7, 16'hBBBB, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd0,
                    1'b1, 1'b1, 1'b0, 4'd7, 16'hBBBB, 1'b0, 1'b0};

        // Reset with requests presented: nothing may be accepted.
        rst = 1'b1;
        drive(1'b1, 4'd3, 16'h1234, 1'b1, 4'd4, 16'h4444, 4'd3, 4'd4);
        step();
        @(negedge clk);
        check("rst.rdy0", {15'd0, req0_ready}, 16'd0);
        check("rst.rdy1", {15'd0, req1_ready}, 16'd0);
        check_idle("rst");
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1,
                  vecs[i].s1, vecs[i].s2);
            @(negedge clk);
            check($sformatf("vec%0d.rdy0", i), {15'd0, req0_ready}, {15'd0, vecs[i].rdy0});
            check($sformatf("vec%0d.rdy1", i), {15'd0, req1_ready}, {15'd0, vecs[i].rdy1});
            check($sformatf("vec%0d.wr", i),   {15'd0, WriteReg},   {15'd0, vecs[i].wr});
            check($sformatf("vec%0d.dst", i),  {12'd0, DstReg},     {12'd0, vecs[i].dst});
            check($sformatf("vec%0d.dat", i),  DstData,             vecs[i].dat);
            check($sformatf("vec%0d.p1", i),   {15'd0, SrcPend1},   {15'd0, vecs[i].p1});
            check($sformatf("vec%0d.p2", i),   {15'd0, SrcPend2},   {15'd0, vecs[i].p2});
            step();
        end

        // Contention: both ports always valid on regs 5 and 6; writes must alternate.
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd6);
        step();
        rst = 1'b0;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 4'd5, 16'h5000 + 16'(n0), 1'b1, 4'd6, 16'h6000 + 16'(n1), 4'd5, 4'd6);
            @(negedge clk);
            h0 = req0_ready;
            h1 = req1_ready;
            if (c >= 2) begin
                k       = c - 2;
                exp_reg = (k % 2 == 1) ? 4'd6 : 4'd5;
                exp_dat = ((k % 2 == 1) ? 16'h6000 : 16'h5000) + 16'(k / 2);
                check($sformatf("rr%0d.wr", k),  {15'd0, WriteReg}, 16'd1);
                check($sformatf("rr%0d.dst", k), {12'd0, DstReg},   {12'd0, exp_reg});
                check($sformatf("rr%0d.dat", k), DstData,           exp_dat);
            end
            step();
            if (h0) n0++;
            if (h1) n1++;
        end

        // Both slots full here; a one-cycle reset must discard them entirely.
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd6);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.rdy0", {15'd0, req0_ready}, 16'd0);
        check("mrst.rdy1", {15'd0, req1_ready}, 16'd0);
        check("mrst.p1",   {15'd0, SrcPend1},   16'd0);
        check("mrst.p2",   {15'd0, SrcPend2},   16'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("post%0d", c));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
